mul_add_reconstructor: RTL and testbench
========================================

Name: mul_add_reconstructor

Overview:
- Sequential shift-add multiply-accumulate that inverts the team's sequential divider: computes dividend = quotient * divisor + remainder.
- Feeds the divider-check datapath: divider outputs come in, the reconstructed dividend is compared against the original operand.
- One bit of the multiplier is processed per clock, with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand width; product is 2*WIDTH bits

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
multiplier  input  WIDTH  quotient operand
multiplicand  input  WIDTH  divisor operand
addend  input  WIDTH  remainder operand
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when product is valid
product  output  2*WIDTH  reconstructed dividend; holds until next done
tempMultiplicand  output  2*WIDTH  live shifted multiplicand register (debug mirror of divider tempDivisor)

Behaviour:
- Reset: reset_n low asynchronously forces the following, regardless of clock:
  - state=IDLE, busy=0, done=0, product=0, tempMultiplicand=0.
  - Internal acc, multiplier shift register and count are cleared.
- Reset mid-operation: reset_n low in RUN aborts the operation. No done pulse. After release the block sits in IDLE.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - On a rising edge with start=1, latch the operands:
    - acc = zero-extended addend
    - tempMultiplicand = zero-extended multiplicand
    - mreg = multiplier
    - count = WIDTH
  - Go to RUN.
  - With start=0, stay in IDLE.
- RUN, each edge:
  - If mreg[0]=1 then acc = acc + tempMultiplicand (2*WIDTH-bit add).
  - tempMultiplicand <<= 1; mreg >>= 1; count -= 1.
  - On the edge where count goes 1->0, go to DONE, load product with the final acc (the value including this edge's add) and set done=1.
- DONE: lasts exactly one cycle with done=1, then go to IDLE and return done to 0.
- Latency:
  - Start is sampled at edge E0. done is high from edge E0+WIDTH to edge E0+WIDTH+1, i.e. WIDTH cycles after acceptance.
  - Fixed latency; no early termination on zero operands.
- busy=1 exactly in RUN (WIDTH cycles). busy=0 in IDLE and DONE.
- start is ignored in RUN and DONE; it is not queued.
  - If start is held high continuously, the next acceptance is at the edge after DONE.
  - Accepted operations are therefore WIDTH+2 cycles apart.
- Operand inputs are sampled only at acceptance. Changes during RUN/DONE have no effect.
- Width: the maximum result (2^W-1)^2 + (2^W-1) = 2^2W - 2^W is below 2^2W, so there is no overflow. No carry-out port.
- product changes only on the DONE-entry edge or on reset.
- tempMultiplicand keeps its last shifted value in IDLE until the next acceptance.

Test Plan:
1. WIDTH=8, reset then multiplier=3, multiplicand=2, addend=1, start pulse -> busy high for 8 cycles, done pulses once 8 cycles after acceptance, product=7.
2. multiplier=0, multiplicand=0, addend=0 -> product=0 with the same fixed 8-cycle latency; done still pulses.
3. multiplier=255, multiplicand=255, addend=255 -> product=65280 (0xFF00); tempMultiplicand=0xFF00 after the final shift.
4. start held high, operands (7,5,3) then changed to (10,10,9) during RUN -> first product=38. Second acceptance occurs 10 cycles after the first and yields 109, using the operands present at that edge.
5. Start (200,100,50), deassert reset_n at RUN cycle 4 -> all outputs 0 immediately (asynchronous), no done pulse. After release, a start with (12,12,0) -> product=144.
6. start asserted while busy=1 (single pulse mid-RUN) -> ignored; exactly one done pulse and product reflects only the first operation.

Source files
------------

// File: rtl/mul_add_reconstructor.sv
// Sequential shift-add multiply-accumulate: product = multiplier * multiplicand + addend.
// Handles one multiplier bit per clock and mirrors the divider's shifted-operand register.
module mul_add_reconstructor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     addend,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [2*WIDTH-1:0]   tempMultiplicand
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   tmc_q, tmc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     mreg_q, mreg_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   acc_sum;

    // Sum including this edge's partial product, so the last step can load product directly.
    always_comb begin
        acc_sum = acc_q;
        if (mreg_q[0]) begin
            acc_sum = acc_q + tmc_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tmc_d     = tmc_q;
        product_d = product_q;
        mreg_d    = mreg_q;
        count_d   = count_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = {{WIDTH{1'b0}}, addend};
                    tmc_d   = {{WIDTH{1'b0}}, multiplicand};
                    mreg_d  = multiplier;
                    count_d = CntW'(WIDTH);
                    state_d = StRun;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                acc_d   = acc_sum;
                tmc_d   = tmc_q << 1;
                mreg_d  = mreg_q >> 1;
                count_d = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    state_d   = StDone;
                    product_d = acc_sum;
                    done_d    = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            tmc_q     <= '0;
            product_q <= '0;
            mreg_q    <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tmc_q     <= tmc_d;
            product_q <= product_d;
            mreg_q    <= mreg_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign product          = product_q;
    assign tempMultiplicand = tmc_q;

endmodule

// File: tb/tb_mul_add_reconstructor.sv
// Directed self-checking bench for mul_add_reconstructor (WIDTH=8).
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_mul_add_reconstructor;

    localparam int unsigned W = 8;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [W-1:0]     multiplier;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     addend;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;
    logic [2*W-1:0]   tempMultiplicand;

    int errors = 0;
    int checks = 0;

    mul_add_reconstructor #(.WIDTH(W)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .multiplier       (multiplier),
        .multiplicand     (multiplicand),
        .addend           (addend),
        .busy             (busy),
        .done             (done),
        .product          (product),
        .tempMultiplicand (tempMultiplicand)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulses start for one edge, then samples 12 cycles starting #1 after acceptance.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] c, input logic [W-1:0] a,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output logic [2*W-1:0] tmc_at_done);
        lat = -1; busy_cnt = 0; done_cnt = 0; tmc_at_done = 'x;
        @(negedge clock);
        multiplier = m; multiplicand = c; addend = a; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                @(posedge clock);
                #1;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = i;
                    tmc_at_done = tempMultiplicand;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0;
        multiplier = '0; multiplicand = '0; addend = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (product !== 16'd0) begin
            errors++; $display("FAIL reset_product got %0d want 0", product); end
        checks++; if (tempMultiplicand !== 16'd0) begin
            errors++; $display("FAIL reset_tmc got %h want 0", tempMultiplicand); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        logic [2*W-1:0] tmc;
        run_op(8'd3, 8'd2, 8'd1, lat, bc, dc, tmc);
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
        checks++; if (bc != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
        checks++; if (dc != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", dc); end
        checks++; if (product !== 16'd7) begin
            errors++; $display("FAIL basic_product got %0d want 7", product); end
        checks++; if (tempMultiplicand !== 16'h0200) begin
            errors++; $display("FAIL basic_tmc_idle got %h want 0200", tempMultiplicand); end
    endtask

    task automatic test_zero();
        int lat, bc, dc;
        logic [2*W-1:0] tmc;
        run_op(8'd0, 8'd0, 8'd0, lat, bc, dc, tmc);
        checks++; if (lat != 8) begin errors++; $display("FAIL zero_latency got %0d want 8", lat); end
        checks++; if (dc != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", dc); end
        checks++; if (product !== 16'd0) begin
            errors++; $display("FAIL zero_product got %0d want 0", product); end
    endtask

    task automatic test_max();
        int lat, bc, dc;
        logic [2*W-1:0] tmc;
        run_op(8'd255, 8'd255, 8'd255, lat, bc, dc, tmc);
        checks++; if (lat != 8) begin errors++; $display("FAIL max_latency got %0d want 8", lat); end
        checks++; if (product !== 16'hFF00) begin
            errors++; $display("FAIL max_product got %h want ff00", product); end
        checks++; if (tmc !== 16'hFF00) begin
            errors++; $display("FAIL max_tmc_at_done got %h want ff00", tmc); end
        checks++; if (tempMultiplicand !== 16'hFF00) begin
            errors++; $display("FAIL max_tmc_hold got %h want ff00", tempMultiplicand); end
    endtask

    // Start held high; operands change right after the first acceptance.
    task automatic test_back_to_back();
        int first_done = -1, second_done = -1, rise = -1, dc = 0;
        logic [2*W-1:0] p1 = 'x, p2 = 'x;
        @(negedge clock);
        multiplier = 8'd7; multiplicand = 8'd5; addend = 8'd3; start = 1'b1;
        @(posedge clock);
        #1 multiplier = 8'd10; multiplicand = 8'd10; addend = 8'd9;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                dc++;
                if (first_done < 0) begin first_done = i; p1 = product; end
                else if (second_done < 0) begin second_done = i; p2 = product; end
            end
            if (busy === 1'b1 && first_done > 0 && rise < 0) begin
                rise = i;
                start = 1'b0;
            end
        end
        checks++; if (first_done != 8) begin
            errors++; $display("FAIL b2b_first_latency got %0d want 8", first_done); end
        checks++; if (p1 !== 16'd38) begin
            errors++; $display("FAIL b2b_first_product got %0d want 38", p1); end
        checks++; if (rise != 10) begin
            errors++; $display("FAIL b2b_second_accept got %0d want 10", rise); end
        checks++; if (second_done != 18) begin
            errors++; $display("FAIL b2b_second_latency got %0d want 18", second_done); end
        checks++; if (p2 !== 16'd109) begin
            errors++; $display("FAIL b2b_second_product got %0d want 109", p2); end
        checks++; if (dc != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dc); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, dc, dc_rst = 0;
        logic [2*W-1:0] tmc;
        @(negedge clock);
        multiplier = 8'd200; multiplicand = 8'd100; addend = 8'd50; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (product !== 16'd0) begin
            errors++; $display("FAIL midrst_product got %0d want 0", product); end
        checks++; if (tempMultiplicand !== 16'd0) begin
            errors++; $display("FAIL midrst_tmc got %h want 0", tempMultiplicand); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) dc_rst++;
            if (i == 2) reset_n = 1'b1;
        end
        checks++; if (dc_rst != 0) begin
            errors++; $display("FAIL midrst_no_done got %0d want 0", dc_rst); end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL midrst_idle_busy got %b want 0", busy); end
        run_op(8'd12, 8'd12, 8'd0, lat, bc, dc, tmc);
        checks++; if (lat != 8) begin errors++; $display("FAIL midrst_latency got %0d want 8", lat); end
        checks++; if (product !== 16'd144) begin
            errors++; $display("FAIL midrst_product_after got %0d want 144", product); end
    endtask

    task automatic test_start_while_busy();
        int first_done = -1, dc = 0;
        @(negedge clock);
        multiplier = 8'd9; multiplicand = 8'd6; addend = 8'd2; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                dc++;
                if (first_done < 0) first_done = i;
            end
            if (i == 3) begin
                multiplier = 8'd1; multiplicand = 8'd1; addend = 8'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (first_done != 8) begin
            errors++; $display("FAIL busy_start_latency got %0d want 8", first_done); end
        checks++; if (dc != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", dc); end
        checks++; if (product !== 16'd56) begin
            errors++; $display("FAIL busy_start_product got %0d want 56", product); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_back_to_back();
        test_reset_mid_run();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
